alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX issue stage that feeds the ALU.
- Decodes a 32-bit RV32I integer/ALU instruction and produces the ALUOp code, the A/B operands and the writeback control.
- Holds them in a single-entry pipeline register with valid/ready handshakes on both sides.
- Sits between the register-file read port and the ALU. It is the producer of the ALUOp encoding that the ALU consumes.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
InValid  in  1  instruction/operands present
InReady  out  1  stage can accept this cycle
Instr  in  32  raw instruction word
PC  in  32  instruction address
Rs1Data  in  32  register-file rs1 value
Rs2Data  in  32  register-file rs2 value
Flush  in  1  kill held and incoming entry
OutValid  out  1  issued bundle valid
OutReady  in  1  ALU/EX side accepts
ALUA  out  32  ALU operand A
ALUB  out  32  ALU operand B
ALUOp  out  4  ALU operation code
RdAddr  out  5  destination register
RegWrite  out  1  writeback enable
Illegal  out  1  instruction not decodable by this stage

Behaviour:
- Clock and reset are fixed: single clock clk; reset rst_n is synchronous and active-low.
- Reset: on a clk edge with rst_n=0, every output register goes to 0: OutValid, ALUA, ALUB, ALUOp (ADD), RdAddr, RegWrite, Illegal. InReady=1 is then derived combinationally.
- InReady = !OutValid || OutReady. It is combinational and does not depend on InValid.
- Accept: an entry is accepted when InValid && InReady && !Flush. On acceptance, all outputs update on the next edge with OutValid=1. Latency is 1 cycle.
- Hold: while OutValid && !OutReady, every output stays stable. InValid is ignored (InReady=0).
- Drain: OutValid && OutReady with no accept gives OutValid=0 next cycle. Data outputs may hold their last value.
- Simultaneous drain and accept: new entry is loaded with no bubble, giving full throughput.
- Flush has priority over everything except reset. The next edge sets OutValid=0, and any same-cycle input is dropped.
- Flush while stalled discards the held entry.
- Reset mid-stall discards the entry.
- ALUOp encoding:
  - ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100
  - SRL=0101, SRA=1101, OR=0110, AND=0111, PASSB=1001
- OP (opcode 0110011):
  - ALUOp = {funct7[5], funct3}.
  - Legal only if funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
  - ALUA=Rs1Data, ALUB=Rs2Data.
- OP-IMM (0010011):
  - ALUA=Rs1Data, ALUB=sign-extended Instr[31:20].
  - ALUOp = {0, funct3}, except funct3=101 gives {Instr[30], 101}.
  - funct3=001 is legal only if Instr[31:25]=0.
  - funct3=101 is legal only if Instr[31:25] is in {0000000, 0100000}.
  - For shifts, ALUB[4:0] = shamt. Upper bits follow the sign-extension and are ignored by the ALU.
- LUI (0110111): ALUOp=PASSB, ALUB = {Instr[31:12], 12'b0}, ALUA=0.
- AUIPC (0010111): ALUOp=ADD, ALUA=PC, ALUB = {Instr[31:12], 12'b0}.
- Any other opcode or illegal funct: Illegal=1, RegWrite=0, ALUOp=ADD, ALUA=ALUB=0. The entry is still issued with OutValid=1 so EX can trap.
- RdAddr = Instr[11:7].
- RegWrite = legal && RdAddr != 0.
- No arithmetic is performed here. Immediates are sign/zero-extended to XLEN exactly as stated.

Decomposition:
- Shared package riscv_pkg holds:
  - the alu_op_t enum (4-bit encodings above), shared with the ALU;
  - opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC;
  - funct7 constants F7_BASE, F7_ALT.
- One combinational sub-module, alu_op_decode, maps (Instr, PC, Rs1Data, Rs2Data) to an unregistered bundle.
- alu_issue_stage holds only the handshake and register logic.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with InValid=1. Required: OutValid=0, ALUOp=0000, RegWrite=0, and InReady=1 after release.
- add x3,x1,x2 (0x002081B3), Rs1Data=5, Rs2Data=7, OutReady=1. Required one cycle later: OutValid=1, ALUOp=0000, ALUA=5, ALUB=7, RdAddr=3, RegWrite=1. Same stimulus with sub (0x402081B3) gives ALUOp=1000.
- srai x5,x6,3 (0x40335293), Rs1Data=0xFFFF0000. Required: ALUOp=1101, ALUB[4:0]=3, RdAddr=5. lui x1,0x12345 (0x123450B7) gives ALUOp=1001, ALUB=0x12345000.
- Backpressure: issue add, then hold OutReady=0 for 3 cycles with a second instruction waiting. Required: outputs stable, InReady=0. When OutReady=1, the second entry loads the next cycle with no bubble.
- Flush: while stalled with a held entry and InValid=1, assert Flush for 1 cycle. Required: OutValid=0 next cycle and the incoming entry dropped. Repeat the flush during an accept cycle; same result.
- Illegal: Instr=0x00000000 and funct7=0x20 with funct3=001 (0x402091B3). Required for both: OutValid=1, Illegal=1, RegWrite=0, ALUOp=0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU operation encoding consumed by the ALU,
// major opcodes and funct7 patterns used by the issue-stage decoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_ADD = 3'b000;

  function automatic logic [31:0] imm_i_sext(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I integer decode: ALU operation, operands and writeback
// control for one instruction, before the issue register.
module alu_op_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [3:0]  alu_op_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_write_o,
  output logic        illegal_o
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       legal_s;
  alu_op_t    op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic       unused_rs1_field_s;

  assign opcode_s  = instr_i[6:0];
  assign funct3_s  = instr_i[14:12];
  assign funct7_s  = instr_i[31:25];
  assign rd_addr_o = instr_i[11:7];
  // The rs1 index is resolved by the register file; only its data arrives here.
  assign unused_rs1_field_s = ^instr_i[19:15];

  // Opcode/funct legality check and operand selection.
  always_comb begin
    legal_s = 1'b0;
    op_s    = ALU_ADD;
    a_s     = 32'h0000_0000;
    b_s     = 32'h0000_0000;
    case (opcode_s)
      OPC_OP: begin
        if ((funct7_s == F7_BASE) ||
            ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR)))) begin
          legal_s = 1'b1;
          op_s    = alu_op_t'({funct7_s[5], funct3_s});
          a_s     = rs1_data_i;
          b_s     = rs2_data_i;
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (funct3_s == F3_SLL) begin
          legal_s = (funct7_s == F7_BASE);
        end else if (funct3_s == F3_SR) begin
          legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
        end else begin
          legal_s = 1'b1;
        end
        if (legal_s) begin
          // Only the right-shift pair uses instr[30] to pick arithmetic vs logical.
          if (funct3_s == F3_SR) begin
            op_s = alu_op_t'({instr_i[30], funct3_s});
          end else begin
            op_s = alu_op_t'({1'b0, funct3_s});
          end
          a_s = rs1_data_i;
          b_s = imm_i_sext(instr_i);
        end else begin
          op_s = ALU_ADD;
        end
      end
      OPC_LUI: begin
        legal_s = 1'b1;
        op_s    = ALU_PASSB;
        b_s     = imm_u(instr_i);
      end
      OPC_AUIPC: begin
        legal_s = 1'b1;
        op_s    = ALU_ADD;
        a_s     = pc_i;
        b_s     = imm_u(instr_i);
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  assign alu_a_o     = a_s;
  assign alu_b_o     = b_s;
  assign alu_op_o    = op_s;
  assign illegal_o   = !legal_s;
  assign reg_write_o = legal_s && (rd_addr_o != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: single-entry registered bundle in front of the ALU with
// valid/ready handshakes on both sides and a flush that kills held and incoming entries.
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] Rs1Data,
  input  logic [XLEN-1:0] Rs2Data,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] ALUA,
  output logic [XLEN-1:0] ALUB,
  output logic [3:0]      ALUOp,
  output logic [4:0]      RdAddr,
  output logic            RegWrite,
  output logic            Illegal
);

  logic [XLEN-1:0] dec_a_s;
  logic [XLEN-1:0] dec_b_s;
  logic [3:0]      dec_op_s;
  logic [4:0]      dec_rd_s;
  logic            dec_rw_s;
  logic            dec_ill_s;

  logic            accept_s;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            ill_q, ill_d;

  alu_op_decode u_decode (
    .instr_i     (Instr),
    .pc_i        (PC),
    .rs1_data_i  (Rs1Data),
    .rs2_data_i  (Rs2Data),
    .alu_a_o     (dec_a_s),
    .alu_b_o     (dec_b_s),
    .alu_op_o    (dec_op_s),
    .rd_addr_o   (dec_rd_s),
    .reg_write_o (dec_rw_s),
    .illegal_o   (dec_ill_s)
  );

  assign InReady  = !valid_q || OutReady;
  assign accept_s = InValid && InReady && !Flush;

  // Next-state: flush kills everything, accept loads (also covers drain+accept), drain clears valid.
  always_comb begin
    valid_d  = valid_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    ill_d    = ill_q;
    if (Flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d  = 1'b1;
      alu_a_d  = dec_a_s;
      alu_b_d  = dec_b_s;
      alu_op_d = dec_op_s;
      rd_d     = dec_rd_s;
      rw_d     = dec_rw_s;
      ill_d    = dec_ill_s;
    end else if (InReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Issue register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= ALU_ADD;
      rd_q     <= 5'd0;
      rw_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      ill_q    <= ill_d;
    end
  end

  assign OutValid = valid_q;
  assign ALUA     = alu_a_q;
  assign ALUB     = alu_b_q;
  assign ALUOp    = alu_op_q;
  assign RdAddr   = rd_q;
  assign RegWrite = rw_q;
  assign Illegal  = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scenarios plus randomized handshake/decode traffic checked against
// a table-driven reference model of the issue stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, InValid, InReady, Flush, OutValid, OutReady;
  logic [31:0] Instr, PC, Rs1Data, Rs2Data, ALUA, ALUB;
  logic [3:0]  ALUOp;
  logic [4:0]  RdAddr;
  logic        RegWrite, Illegal;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .PC(PC), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
    .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
    .ALUA(ALUA), .ALUB(ALUB), .ALUOp(ALUOp), .RdAddr(RdAddr),
    .RegWrite(RegWrite), .Illegal(Illegal)
  );

  // Reference decode straight from the instruction-set tables.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0] names [0:7];
    exp_t e;
    logic ok;
    logic alt;
    int   f3;
    int   f7;
    names = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    e   = '0;
    ok  = 1'b0;
    alt = 1'b0;
    if (ins[6:0] == 7'h33) begin
      ok  = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      alt = (f7 == 32);
      e.a = r1;
      e.b = r2;
    end else if (ins[6:0] == 7'h13) begin
      ok  = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
      alt = (f3 == 5) && ins[30];
      e.a = r1;
      e.b = 32'($signed(ins[31:20]));
    end else if (ins[6:0] == 7'h37) begin
      ok  = 1'b1;
      e.b = ins & 32'hFFFF_F000;
    end else if (ins[6:0] == 7'h17) begin
      ok  = 1'b1;
      e.a = pc;
      e.b = ins & 32'hFFFF_F000;
    end
    e.op = names[f3];
    if (alt && f3 == 0) e.op = 4'd8;
    if (alt && f3 == 5) e.op = 4'd13;
    if (ins[6:0] == 7'h37) e.op = 4'd9;
    if (ins[6:0] == 7'h17) e.op = 4'd0;
    e.rd  = ins[11:7];
    e.ill = !ok;
    e.rw  = ok && (e.rd != 5'd0);
    if (!ok) begin
      e.a  = 32'd0;
      e.b  = 32'd0;
      e.op = 4'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: opc = 7'h33;
      3, 4, 5: opc = 7'h13;
      6:       opc = 7'h37;
      7:       opc = 7'h17;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = '{ALUA, ALUB, ALUOp, RdAddr, RegWrite, Illegal};
    return o;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; InValid = 1'b1; Flush = 1'b0; OutReady = 1'b0;
    Instr = 32'h002081B3; PC = 32'h100; Rs1Data = 32'd5; Rs2Data = 32'd7;
    step();
    step();
    checks++; if (OutValid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", OutValid); else passed++;
    checks++; if (ALUOp !== 4'd0 || RegWrite !== 1'b0 || ALUA !== 32'd0 || Illegal !== 1'b0)
      $display("FAIL reset_data op=%h rw=%b a=%h ill=%b exp all 0", ALUOp, RegWrite, ALUA, Illegal);
    else passed++;
    rst_n = 1'b1; InValid = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) $display("FAIL reset_inready got=%b exp=1", InReady); else passed++;
    step();
  endtask

  task automatic test_add_sub();
    OutReady = 1'b1; InValid = 1'b1; Rs1Data = 32'd5; Rs2Data = 32'd7;
    Instr = 32'h002081B3;
    step();
    checks++; if (OutValid !== 1'b1 || observed() !== exp_t'({32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0}))
      $display("FAIL add v=%b got=%h exp=%h", OutValid, observed(), exp_t'({32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b0}));
    else passed++;
    Instr = 32'h402081B3;
    step();
    checks++; if (OutValid !== 1'b1 || ALUOp !== 4'b1000 || ALUA !== 32'd5 || ALUB !== 32'd7)
      $display("FAIL sub v=%b op=%b a=%h b=%h exp op=1000", OutValid, ALUOp, ALUA, ALUB);
    else passed++;
    InValid = 1'b0;
    step();
    checks++; if (OutValid !== 1'b0) $display("FAIL drain got=%b exp=0", OutValid); else passed++;
  endtask

  task automatic test_srai_lui();
    OutReady = 1'b1; InValid = 1'b1; Rs1Data = 32'hFFFF_0000; Rs2Data = 32'h1234;
    Instr = 32'h40335293;
    step();
    checks++; if (OutValid !== 1'b1 || ALUOp !== 4'b1101 || ALUB[4:0] !== 5'd3 || RdAddr !== 5'd5 ||
                  ALUA !== 32'hFFFF_0000 || RegWrite !== 1'b1)
      $display("FAIL srai op=%b b=%h rd=%0d a=%h exp op=1101 b[4:0]=3 rd=5", ALUOp, ALUB, RdAddr, ALUA);
    else passed++;
    Instr = 32'h123450B7;
    step();
    checks++; if (ALUOp !== 4'b1001 || ALUB !== 32'h1234_5000 || ALUA !== 32'd0 || RdAddr !== 5'd1)
      $display("FAIL lui op=%b b=%h a=%h rd=%0d exp op=1001 b=12345000", ALUOp, ALUB, ALUA, RdAddr);
    else passed++;
    InValid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b0; InValid = 1'b1; Rs1Data = 32'd5; Rs2Data = 32'd7;
    Instr = 32'h002081B3;
    step();
    Instr = 32'h402081B3; Rs1Data = 32'd11; Rs2Data = 32'd22;
    for (int i = 0; i < 3; i++) begin
      checks++; if (InReady !== 1'b0) $display("FAIL stall_inready cyc=%0d got=%b exp=0", i, InReady); else passed++;
      step();
      checks++; if (OutValid !== 1'b1 || ALUOp !== 4'd0 || ALUA !== 32'd5 || ALUB !== 32'd7)
        $display("FAIL stall_hold cyc=%0d v=%b op=%h a=%h b=%h exp add 5,7", i, OutValid, ALUOp, ALUA, ALUB);
      else passed++;
    end
    OutReady = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) $display("FAIL release_inready got=%b exp=1", InReady); else passed++;
    step();
    checks++; if (OutValid !== 1'b1 || ALUOp !== 4'b1000 || ALUA !== 32'd11 || ALUB !== 32'd22)
      $display("FAIL no_bubble v=%b op=%h a=%h b=%h exp sub 11,22", OutValid, ALUOp, ALUA, ALUB);
    else passed++;
    InValid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    OutReady = 1'b0; InValid = 1'b1; Instr = 32'h002081B3;
    step();
    Instr = 32'h402081B3; Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    checks++; if (OutValid !== 1'b0) $display("FAIL flush_stall got=%b exp=0", OutValid); else passed++;
    step();
    checks++; if (OutValid !== 1'b0) $display("FAIL flush_drop got=%b exp=0", OutValid); else passed++;
    OutReady = 1'b1; InValid = 1'b1; Flush = 1'b1;
    step();
    Flush = 1'b0; InValid = 1'b0;
    checks++; if (OutValid !== 1'b0) $display("FAIL flush_accept got=%b exp=0", OutValid); else passed++;
    OutReady = 1'b0; InValid = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; InValid = 1'b0;
    checks++; if (OutValid !== 1'b0) $display("FAIL reset_stall got=%b exp=0", OutValid); else passed++;
  endtask

  task automatic test_illegal();
    OutReady = 1'b1; InValid = 1'b1; Rs1Data = 32'hAAAA; Rs2Data = 32'h5555;
    Instr = 32'h0000_0000;
    step();
    checks++; if (OutValid !== 1'b1 || Illegal !== 1'b1 || RegWrite !== 1'b0 || ALUOp !== 4'd0 ||
                  ALUA !== 32'd0 || ALUB !== 32'd0)
      $display("FAIL illegal_zero v=%b ill=%b rw=%b op=%h a=%h b=%h", OutValid, Illegal, RegWrite, ALUOp, ALUA, ALUB);
    else passed++;
    Instr = 32'h402091B3;
    step();
    checks++; if (OutValid !== 1'b1 || Illegal !== 1'b1 || RegWrite !== 1'b0 || ALUOp !== 4'd0 ||
                  ALUA !== 32'd0 || ALUB !== 32'd0)
      $display("FAIL illegal_f7 v=%b ill=%b rw=%b op=%h a=%h b=%h", OutValid, Illegal, RegWrite, ALUOp, ALUA, ALUB);
    else passed++;
    InValid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic exp_v;
    logic exp_rdy;
    exp_t exp_e;
    exp_v = 1'b0;
    exp_e = '0;
    for (int i = 0; i < 600; i++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      Flush    = ($urandom_range(0, 15) == 0);
      Instr    = rand_instr();
      PC       = $urandom;
      Rs1Data  = $urandom;
      Rs2Data  = $urandom;
      #1;
      exp_rdy = !exp_v || OutReady;
      checks++; if (InReady !== exp_rdy) $display("FAIL rnd_inready i=%0d got=%b exp=%b", i, InReady, exp_rdy); else passed++;
      if (Flush) exp_v = 1'b0;
      else if (InValid && exp_rdy) begin
        exp_v = 1'b1;
        exp_e = model(Instr, PC, Rs1Data, Rs2Data);
      end else if (exp_rdy) exp_v = 1'b0;
      step();
      checks++; if (OutValid !== exp_v) $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, OutValid, exp_v); else passed++;
      if (exp_v) begin
        checks++; if (observed() !== exp_e)
          $display("FAIL rnd_bundle i=%0d instr=%h got=%h exp=%h", i, Instr, observed(), exp_e);
        else passed++;
      end
    end
    InValid = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_srai_lui();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
